// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares one SDRAM controller command/data port between the VGA line-fill
//   requester (priority, 256-word read bursts) and a CPU single-word
//   requester. A saturating wait counter lets a starved CPU win the next
//   IDLE arbitration. Grants only happen from IDLE, so an in-flight burst
//   always runs to completion.
//
// Ports
//   clk_sys_i, rst_i           clock, synchronous active-high reset
//   line_req_i / line_grant_o  line-fill request (level) / grant (level)
//   line_addr_i                line-fill burst start address
//   line_data_o, line_valid_o  burst read data, pass-through from mem_rdata_i
//   line_done_o                burst complete pulse
//   cpu_req_i, cpu_we_i        CPU request (level) and direction
//   cpu_addr_i, cpu_wdata_i    CPU word address and write data
//   cpu_ack_o, cpu_rdata_o     CPU completion pulse and read data
//   mem_cmd_*_o, mem_cmd_ready_i, mem_wdata_o   command port to the controller
//   mem_rdata_i, mem_rdata_valid_i, mem_done_i  controller responses
//   arb_state_o                FSM state for debug
module sdram_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int BURST_LEN    = 256,
    parameter int LEN_W        = 9,
    parameter int CPU_MAX_WAIT = 64
) (
    input  logic              clk_sys_i,
    input  logic              rst_i,
    input  logic              line_req_i,
    output logic              line_grant_o,
    input  logic [ADDR_W-1:0] line_addr_i,
    output logic [DATA_W-1:0] line_data_o,
    output logic              line_valid_o,
    output logic              line_done_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              mem_cmd_valid_o,
    input  logic              mem_cmd_ready_i,
    output logic              mem_cmd_we_o,
    output logic [ADDR_W-1:0] mem_cmd_addr_o,
    output logic [LEN_W-1:0]  mem_cmd_len_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rdata_valid_i,
    input  logic              mem_done_i,
    output logic [2:0]        arb_state_o
);

    localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LINE_CMD  = 3'd1,
        LINE_XFER = 3'd2,
        CPU_CMD   = 3'd3,
        CPU_XFER  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rd_seen_q, rd_seen_d;
    logic                ack_q, ack_d;
    logic                cpu_win;
    logic                cpu_busy;

    // ack_q blocks a re-grant on the still-high cpu_req during the ack cycle.
    assign cpu_win  = (state_q == IDLE) && cpu_req_i && !ack_q &&
                      (!line_req_i || (wait_q == WAIT_MAX));
    assign cpu_busy = (state_q == CPU_CMD) || (state_q == CPU_XFER);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        len_d     = len_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rd_seen_d = rd_seen_q;
        ack_d     = 1'b0;
        wait_d    = wait_q;

        if (cpu_win) begin
            wait_d = '0;
        end else if (cpu_req_i && !cpu_busy && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (cpu_win) begin
                    state_d   = CPU_CMD;
                    addr_d    = cpu_addr_i;
                    we_d      = cpu_we_i;
                    wdata_d   = cpu_wdata_i;
                    len_d     = LEN_W'(1);
                    rd_seen_d = 1'b0;
                end else if (line_req_i) begin
                    state_d = LINE_CMD;
                    addr_d  = line_addr_i;
                    we_d    = 1'b0;
                    len_d   = LEN_W'(BURST_LEN);
                end
            end
            LINE_CMD: if (mem_cmd_ready_i) state_d = LINE_XFER;
            CPU_CMD:  if (mem_cmd_ready_i) state_d = CPU_XFER;
            LINE_XFER: if (mem_done_i) state_d = IDLE;
            CPU_XFER: begin
                // Only the first returned word is the answer to a read.
                if (!we_q && mem_rdata_valid_i && !rd_seen_q) begin
                    rdata_d   = mem_rdata_i;
                    rd_seen_d = 1'b1;
                end
                if (mem_done_i) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            len_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rd_seen_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            len_q     <= len_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rd_seen_q <= rd_seen_d;
            ack_q     <= ack_d;
        end
    end

    assign line_grant_o    = (state_q == LINE_CMD) || (state_q == LINE_XFER);
    assign line_valid_o    = (state_q == LINE_XFER) && mem_rdata_valid_i;
    assign line_done_o     = (state_q == LINE_XFER) && mem_done_i;
    assign line_data_o     = (state_q == LINE_XFER) ? mem_rdata_i : '0;
    assign mem_cmd_valid_o = (state_q == LINE_CMD) || (state_q == CPU_CMD);
    assign mem_cmd_we_o    = we_q;
    assign mem_cmd_addr_o  = addr_q;
    assign mem_cmd_len_o   = len_q;
    assign mem_wdata_o     = wdata_q;
    assign cpu_ack_o       = ack_q;
    assign cpu_rdata_o     = rdata_q;
    assign arb_state_o     = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;
    localparam int ADDR_W = 24, DATA_W = 16, BURST_LEN = 256, LEN_W = 9, CPU_MAX_WAIT = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, line_req, line_grant, line_valid, line_done;
    logic [ADDR_W-1:0] line_addr, cpu_addr, mem_cmd_addr;
    logic [DATA_W-1:0] line_data, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
    logic              cpu_req, cpu_we, cpu_ack;
    logic              mem_cmd_valid, mem_cmd_ready, mem_cmd_we, mem_rdata_valid, mem_done;
    logic [LEN_W-1:0]  mem_cmd_len;
    logic [2:0]        arb_state;

    int errors = 0;
    int checks = 0;

    sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
                    .LEN_W(LEN_W), .CPU_MAX_WAIT(CPU_MAX_WAIT)) dut (
        .clk_sys_i(clk), .rst_i(rst),
        .line_req_i(line_req), .line_grant_o(line_grant), .line_addr_i(line_addr),
        .line_data_o(line_data), .line_valid_o(line_valid), .line_done_o(line_done),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
        .mem_cmd_valid_o(mem_cmd_valid), .mem_cmd_ready_i(mem_cmd_ready),
        .mem_cmd_we_o(mem_cmd_we), .mem_cmd_addr_o(mem_cmd_addr),
        .mem_cmd_len_o(mem_cmd_len), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_rdata_valid_i(mem_rdata_valid),
        .mem_done_i(mem_done), .arb_state_o(arb_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        mem_cmd_ready = 1'b0; mem_rdata_valid = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; line_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        line_addr = '0; cpu_addr = '0; cpu_wdata = '0;
        quiet();
        tick(); tick();
        rst = 1'b0;
    endtask

    // Starts in LINE_CMD: accepts the command at once, then spends n cycles
    // in the transfer (n-1 data beats, then mem_done). Ends in IDLE.
    task automatic line_burst(input int n, output int off_state, output int ndone);
        off_state = 0; ndone = 0;
        mem_cmd_ready = 1'b1; tick(); mem_cmd_ready = 1'b0;
        for (int i = 0; i < n - 1; i++) begin
            mem_rdata_valid = 1'b1; mem_rdata = 16'(i); #1;
            if (arb_state !== 3'd2) off_state++;
            if (line_done) ndone++;
            tick();
        end
        mem_rdata_valid = 1'b0; mem_done = 1'b1; #1;
        if (arb_state !== 3'd2) off_state++;
        if (line_done) ndone++;
        tick();
        mem_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (arb_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", arb_state); end
        checks++; if ({line_grant, line_valid, line_done, cpu_ack, mem_cmd_valid, mem_cmd_we} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000000",
                {line_grant, line_valid, line_done, cpu_ack, mem_cmd_valid, mem_cmd_we}); end
        checks++; if ({cpu_rdata, mem_cmd_addr, mem_cmd_len, mem_wdata} !== 65'd0) begin
            errors++; $display("FAIL reset_data: rdata=%h addr=%h len=%0d wdata=%h expected all 0",
                cpu_rdata, mem_cmd_addr, mem_cmd_len, mem_wdata); end
    endtask

    task automatic test_line_only();
        int nvalid, ndone, bad;
        do_reset();
        line_addr = 24'h000400; line_req = 1'b1;
        tick();
        checks++; if ({arb_state, line_grant, mem_cmd_valid} !== {3'd1, 1'b1, 1'b1}) begin
            errors++; $display("FAIL line_cmd: state=%0d grant=%b valid=%b expected 1 1 1", arb_state, line_grant, mem_cmd_valid); end
        checks++; if ({mem_cmd_addr, mem_cmd_len, mem_cmd_we} !== {24'h000400, 9'd256, 1'b0}) begin
            errors++; $display("FAIL line_cmd_fields: addr=%h len=%0d we=%b expected 000400 256 0", mem_cmd_addr, mem_cmd_len, mem_cmd_we); end
        line_addr = 24'h00ABCD;
        tick(); tick();
        checks++; if ({arb_state, mem_cmd_valid, mem_cmd_addr} !== {3'd1, 1'b1, 24'h000400}) begin
            errors++; $display("FAIL line_cmd_hold: state=%0d valid=%b addr=%h expected 1 1 000400", arb_state, mem_cmd_valid, mem_cmd_addr); end
        mem_cmd_ready = 1'b1; tick(); mem_cmd_ready = 1'b0;
        checks++; if ({arb_state, mem_cmd_valid, line_grant} !== {3'd2, 1'b0, 1'b1}) begin
            errors++; $display("FAIL line_xfer_entry: state=%0d valid=%b grant=%b expected 2 0 1", arb_state, mem_cmd_valid, line_grant); end
        nvalid = 0; ndone = 0; bad = 0;
        for (int i = 0; i < 256; i++) begin
            mem_rdata_valid = 1'b1; mem_rdata = 16'(i * 3 + 1); #1;
            if (line_valid) nvalid++;
            if (line_data !== 16'(i * 3 + 1)) bad++;
            if (line_done) ndone++;
            tick();
        end
        mem_rdata_valid = 1'b0; mem_done = 1'b1; #1;
        checks++; if ({line_done, line_grant} !== 2'b11) begin
            errors++; $display("FAIL line_done_pulse: done=%b grant=%b expected 1 1", line_done, line_grant); end
        if (line_done) ndone++;
        tick();
        mem_done = 1'b0; line_req = 1'b0; #1;
        checks++; if ({arb_state, line_grant, line_done} !== {3'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL line_end: state=%0d grant=%b done=%b expected 0 0 0", arb_state, line_grant, line_done); end
        checks++; if (nvalid !== 256) begin errors++; $display("FAIL line_valid_count: got %0d expected 256", nvalid); end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL line_done_count: got %0d expected 1", ndone); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL line_data: %0d beats wrong expected 0", bad); end
    endtask

    task automatic test_cpu_write_read();
        do_reset();
        cpu_addr = 24'h7FF000; cpu_we = 1'b1; cpu_wdata = 16'h1234; cpu_req = 1'b1;
        tick();
        checks++; if ({arb_state, mem_cmd_valid, mem_cmd_we, mem_cmd_len, mem_cmd_addr, mem_wdata} !==
                      {3'd3, 1'b1, 1'b1, 9'd1, 24'h7FF000, 16'h1234}) begin
            errors++; $display("FAIL cpu_wr_cmd: state=%0d valid=%b we=%b len=%0d addr=%h wdata=%h expected 3 1 1 1 7ff000 1234",
                arb_state, mem_cmd_valid, mem_cmd_we, mem_cmd_len, mem_cmd_addr, mem_wdata); end
        mem_cmd_ready = 1'b1; tick(); mem_cmd_ready = 1'b0;
        checks++; if ({arb_state, mem_cmd_valid} !== {3'd4, 1'b0}) begin
            errors++; $display("FAIL cpu_wr_xfer: state=%0d valid=%b expected 4 0", arb_state, mem_cmd_valid); end
        mem_rdata = 16'hDEAD; mem_rdata_valid = 1'b1; tick(); mem_rdata_valid = 1'b0;
        mem_done = 1'b1; #1;
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL cpu_wr_ack_early: got %b expected 0", cpu_ack); end
        tick(); mem_done = 1'b0;
        checks++; if ({cpu_ack, arb_state, cpu_rdata} !== {1'b1, 3'd0, 16'h0000}) begin
            errors++; $display("FAIL cpu_wr_ack: ack=%b state=%0d rdata=%h expected 1 0 0000", cpu_ack, arb_state, cpu_rdata); end
        tick();
        checks++; if ({cpu_ack, arb_state} !== {1'b0, 3'd0}) begin
            errors++; $display("FAIL cpu_wr_ack_once: ack=%b state=%0d expected 0 0", cpu_ack, arb_state); end
        cpu_req = 1'b0;
        tick();
        cpu_we = 1'b0; cpu_req = 1'b1;
        tick();
        checks++; if ({arb_state, mem_cmd_we, mem_cmd_len, mem_cmd_addr} !== {3'd3, 1'b0, 9'd1, 24'h7FF000}) begin
            errors++; $display("FAIL cpu_rd_cmd: state=%0d we=%b len=%0d addr=%h expected 3 0 1 7ff000",
                arb_state, mem_cmd_we, mem_cmd_len, mem_cmd_addr); end
        mem_cmd_ready = 1'b1; tick(); mem_cmd_ready = 1'b0;
        mem_rdata = 16'h1234; mem_rdata_valid = 1'b1; tick();
        mem_rdata = 16'hBEEF; tick();
        mem_rdata_valid = 1'b0; mem_done = 1'b1; tick(); mem_done = 1'b0;
        checks++; if ({cpu_ack, cpu_rdata} !== {1'b1, 16'h1234}) begin
            errors++; $display("FAIL cpu_rd_ack: ack=%b rdata=%h expected 1 1234", cpu_ack, cpu_rdata); end
        tick(); cpu_req = 1'b0;
        tick();
        checks++; if ({cpu_ack, cpu_rdata} !== {1'b0, 16'h1234}) begin
            errors++; $display("FAIL cpu_rd_hold: ack=%b rdata=%h expected 0 1234", cpu_ack, cpu_rdata); end
    endtask

    task automatic test_simultaneous();
        int off, nd;
        do_reset();
        line_addr = 24'h000100; cpu_addr = 24'h000200; cpu_we = 1'b0;
        line_req = 1'b1; cpu_req = 1'b1;
        tick();
        checks++; if ({arb_state, mem_cmd_addr} !== {3'd1, 24'h000100}) begin
            errors++; $display("FAIL simul_line_first: state=%0d addr=%h expected 1 000100", arb_state, mem_cmd_addr); end
        line_burst(8, off, nd);
        line_req = 1'b0;
        checks++; if ({arb_state, line_grant, off, nd} !== {3'd0, 1'b0, 32'd0, 32'd1}) begin
            errors++; $display("FAIL simul_idle_gap: state=%0d grant=%b off=%0d done=%0d expected 0 0 0 1", arb_state, line_grant, off, nd); end
        tick();
        checks++; if ({arb_state, mem_cmd_addr, mem_cmd_len} !== {3'd3, 24'h000200, 9'd1}) begin
            errors++; $display("FAIL simul_cpu_next: state=%0d addr=%h len=%0d expected 3 000200 1", arb_state, mem_cmd_addr, mem_cmd_len); end
        mem_cmd_ready = 1'b1; tick(); mem_cmd_ready = 1'b0;
        mem_done = 1'b1; tick(); mem_done = 1'b0;
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL simul_cpu_ack: got %b expected 1", cpu_ack); end
        tick(); cpu_req = 1'b0;
    endtask

    task automatic test_starvation();
        int off1, off2, nd1, nd2, off3, nd3;
        do_reset();
        line_addr = 24'h000300; cpu_addr = 24'h000500; cpu_we = 1'b1; cpu_wdata = 16'h5A5A;
        line_req = 1'b1; cpu_req = 1'b1;
        tick();
        // wait reaches 63 at the end of this burst: one short of the limit
        line_burst(61, off1, nd1);
        checks++; if (arb_state !== 3'd0) begin errors++; $display("FAIL starve_idle1: state=%0d expected 0", arb_state); end
        tick();
        checks++; if (arb_state !== 3'd1) begin errors++; $display("FAIL starve_line_at_63: state=%0d expected 1", arb_state); end
        line_burst(10, off2, nd2);
        checks++; if ({off1 + off2, nd1 + nd2} !== {32'd0, 32'd2}) begin
            errors++; $display("FAIL starve_no_preempt: off=%0d dones=%0d expected 0 2", off1 + off2, nd1 + nd2); end
        tick();
        checks++; if ({arb_state, mem_cmd_addr, mem_cmd_we, mem_wdata} !== {3'd3, 24'h000500, 1'b1, 16'h5A5A}) begin
            errors++; $display("FAIL starve_cpu_wins: state=%0d addr=%h we=%b wdata=%h expected 3 000500 1 5a5a",
                arb_state, mem_cmd_addr, mem_cmd_we, mem_wdata); end
        mem_cmd_ready = 1'b1; tick(); mem_cmd_ready = 1'b0;
        mem_done = 1'b1; tick(); mem_done = 1'b0;
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL starve_cpu_ack: got %b expected 1", cpu_ack); end
        tick();
        checks++; if (arb_state !== 3'd1) begin errors++; $display("FAIL starve_line_after_ack: state=%0d expected 1", arb_state); end
        cpu_req = 1'b0;
        line_burst(4, off3, nd3);
        cpu_req = 1'b1;
        tick();
        // wait was cleared by the CPU win, so a fresh contest goes to the line
        checks++; if (arb_state !== 3'd1) begin errors++; $display("FAIL starve_wait_cleared: state=%0d expected 1", arb_state); end
        line_burst(4, off3, nd3);
        line_req = 1'b0;
        tick();
        checks++; if (arb_state !== 3'd3) begin errors++; $display("FAIL starve_cpu_final: state=%0d expected 3", arb_state); end
        mem_cmd_ready = 1'b1; tick(); mem_cmd_ready = 1'b0;
        mem_done = 1'b1; tick(); mem_done = 1'b0;
        tick(); cpu_req = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        int off, nd;
        do_reset();
        line_addr = 24'h000600; line_req = 1'b1;
        tick();
        mem_cmd_ready = 1'b1; tick(); mem_cmd_ready = 1'b0;
        for (int i = 0; i < 101; i++) begin
            mem_rdata_valid = 1'b1; mem_rdata = 16'(i); tick();
        end
        rst = 1'b1; tick(); rst = 1'b0; #1;
        checks++; if ({arb_state, line_grant, mem_cmd_valid, line_done, line_valid} !== {3'd0, 4'b0000}) begin
            errors++; $display("FAIL rst_mid_burst: state=%0d grant=%b cvalid=%b done=%b lvalid=%b expected 0 0 0 0 0",
                arb_state, line_grant, mem_cmd_valid, line_done, line_valid); end
        mem_rdata_valid = 1'b0;
        line_addr = 24'h000800;
        tick();
        checks++; if ({arb_state, mem_cmd_addr, mem_cmd_valid} !== {3'd1, 24'h000800, 1'b1}) begin
            errors++; $display("FAIL rst_rerequest: state=%0d addr=%h valid=%b expected 1 000800 1", arb_state, mem_cmd_addr, mem_cmd_valid); end
        line_burst(4, off, nd);
        line_req = 1'b0;
        checks++; if ({arb_state, nd} !== {3'd0, 32'd1}) begin
            errors++; $display("FAIL rst_rerequest_done: state=%0d dones=%0d expected 0 1", arb_state, nd); end
    endtask

    task automatic test_stray();
        do_reset();
        mem_rdata = 16'hFFFF; mem_rdata_valid = 1'b1; mem_done = 1'b1; #1;
        checks++; if ({line_valid, line_done} !== 2'b00) begin
            errors++; $display("FAIL stray_idle_comb: valid=%b done=%b expected 0 0", line_valid, line_done); end
        tick();
        checks++; if ({arb_state, cpu_ack} !== {3'd0, 1'b0}) begin
            errors++; $display("FAIL stray_idle_state: state=%0d ack=%b expected 0 0", arb_state, cpu_ack); end
        quiet();
        cpu_addr = 24'h000042; cpu_we = 1'b0; cpu_req = 1'b1;
        tick();
        mem_rdata = 16'h7777; mem_rdata_valid = 1'b1; mem_done = 1'b1; #1;
        checks++; if ({line_valid, line_done} !== 2'b00) begin
            errors++; $display("FAIL stray_cmd_comb: valid=%b done=%b expected 0 0", line_valid, line_done); end
        tick();
        checks++; if ({arb_state, cpu_ack, cpu_rdata} !== {3'd3, 1'b0, 16'h0000}) begin
            errors++; $display("FAIL stray_cmd_state: state=%0d ack=%b rdata=%h expected 3 0 0000", arb_state, cpu_ack, cpu_rdata); end
        quiet();
        mem_cmd_ready = 1'b1; tick(); mem_cmd_ready = 1'b0;
        mem_rdata = 16'h9999; mem_rdata_valid = 1'b1; mem_done = 1'b1; tick(); quiet();
        checks++; if ({cpu_ack, cpu_rdata} !== {1'b1, 16'h9999}) begin
            errors++; $display("FAIL stray_then_read: ack=%b rdata=%h expected 1 9999", cpu_ack, cpu_rdata); end
        tick(); cpu_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line_only();
        test_cpu_write_read();
        test_simultaneous();
        test_starvation();
        test_reset_mid_burst();
        test_stray();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller command/data port between the VGA line-fill requester and a CPU single-word requester.
- The line-fill path has priority. A starvation counter grants the CPU a bounded-latency slot, but only at burst boundaries, never by preemption.
- Sits in the clk_sys (100 MHz) domain, between vga_controller's burst interface and the SDRAM controller.

Parameters:
ADDR_W, 24, word address width
DATA_W, 16, data width (RGB565 / CPU word)
BURST_LEN, 256, words per line-fill burst (driven on mem_cmd_len)
LEN_W, 9, width of mem_cmd_len (must hold BURST_LEN)
CPU_MAX_WAIT, 64, cycles a pending CPU request waits before it wins over a pending line request

Ports:
clk_sys  in  1  system clock
rst  in  1  synchronous, active-high reset
line_req  in  1  line-fill request (level; held until line_done)
line_grant  out  1  line-fill burst granted (level)
line_addr  in  ADDR_W  line-fill burst start address
line_data  out  DATA_W  burst read data
line_valid  out  1  line_data valid
line_done  out  1  burst complete (1-cycle pulse)
cpu_req  in  1  CPU request (level; held until cpu_ack)
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  CPU access complete (1-cycle pulse)
cpu_rdata  out  DATA_W  CPU read data
mem_cmd_valid  out  1  command to SDRAM controller
mem_cmd_ready  in  1  controller accepts command
mem_cmd_we  out  1  write command
mem_cmd_addr  out  ADDR_W  command address
mem_cmd_len  out  LEN_W  burst length in words
mem_wdata  out  DATA_W  write data (single word)
mem_rdata  in  DATA_W  read data
mem_rdata_valid  in  1  read data valid
mem_done  in  1  command complete (1-cycle pulse)
arb_state  out  3  FSM state, for debug

Behaviour:
- Reset (rst high at a clk_sys edge):
  - State goes to IDLE and cpu_wait goes to 0.
  - All outputs go to 0: line_grant, line_valid, line_done, cpu_ack, cpu_rdata, mem_cmd_*, mem_wdata, arb_state.
  - Reset mid-burst abandons the transfer with no done/ack pulse; the controller shares rst.
- States (arb_state encoding): IDLE=0, LINE_CMD=1, LINE_XFER=2, CPU_CMD=3, CPU_XFER=4.
- IDLE selection, evaluated each cycle:
  - CPU wins when cpu_req is high, cpu_ack is not high this cycle, and either line_req is low or cpu_wait==CPU_MAX_WAIT.
  - Otherwise, if line_req is high, the line requester wins.
  - Otherwise the FSM stays in IDLE.
- On a line win (IDLE -> LINE_CMD, next edge):
  - Latch line_addr into mem_cmd_addr.
  - Drive mem_cmd_we=0, mem_cmd_len=BURST_LEN, mem_cmd_valid=1, line_grant=1.
- On a CPU win (IDLE -> CPU_CMD, next edge):
  - Latch cpu_addr, cpu_we and cpu_wdata.
  - Drive mem_cmd_len=1, mem_cmd_valid=1.
  - Clear cpu_wait.
- *_CMD states:
  - mem_cmd_valid and all command fields stay stable until mem_cmd_ready is sampled high.
  - Next edge after that: mem_cmd_valid=0 and the FSM moves to the matching *_XFER state.
  - mem_done seen in a *_CMD state is ignored.
- LINE_XFER:
  - line_data = mem_rdata and line_valid = mem_rdata_valid, combinational pass-through (0-cycle latency).
  - line_done = mem_done.
  - On mem_done: go to IDLE and drop line_grant at that edge.
  - line_grant is high from LINE_CMD entry through the mem_done cycle inclusive.
- CPU_XFER:
  - Read: the first mem_rdata_valid is registered into cpu_rdata. cpu_rdata holds until the next CPU read completes.
  - Write: mem_rdata_valid is ignored.
  - On mem_done: cpu_ack=1 for exactly one cycle (registered) and the FSM returns to IDLE.
- cpu_wait:
  - Increments each cycle that cpu_req is high and the state is not CPU_CMD or CPU_XFER.
  - Saturates at CPU_MAX_WAIT and is cleared on a CPU win.
  - Width is clog2(CPU_MAX_WAIT+1).
- Preemption: none. An in-flight burst always completes.
- Outside LINE_XFER, line_valid and line_done are 0; stray mem_rdata_valid and mem_done are ignored.
- Simultaneous line_req and cpu_req in IDLE with cpu_wait<CPU_MAX_WAIT: the line requester wins.
- Turnaround: minimum IDLE dwell between grants is 1 cycle.
- Requester rules:
  - The line requester deasserts line_req on the edge after line_done and may re-request after its block wait.
  - cpu_req must drop the cycle after cpu_ack.

Test Plan:
1. Line only: line_req=1, line_addr=0x000400, mem_cmd_ready after 3 cycles, 256 mem_rdata_valid beats then mem_done -> mem_cmd_addr=0x000400, len=256, we=0; exactly 256 line_valid; one line_done; line_grant low the next cycle.
2. CPU write then read: write 0x1234 to 0x7FF000, then read the same address with mem_rdata=0x1234 -> cmd len=1; we=1 then 0; two cpu_ack pulses; cpu_rdata=0x1234 after the second ack.
3. Simultaneous line_req and cpu_req from IDLE with cpu_wait=0 -> line granted first; CPU granted after line_done plus 1 IDLE cycle; cpu_wait cleared.
4. Starvation: cpu_req held while back-to-back line requests keep arriving, with CPU_MAX_WAIT=64 -> after cpu_wait reaches 64 the CPU wins the next IDLE arbitration even with line_req high; no burst is preempted.
5. Reset mid-burst: assert rst after beat 100 of a line burst -> next edge arb_state=0, line_grant=0, mem_cmd_valid=0, no line_done; new line_req accepted normally after rst deasserts.
6. Stray inputs: mem_rdata_valid or mem_done while in IDLE or CPU_CMD -> no line_valid, line_done or cpu_ack; state unchanged.
